// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared mux_4x1. The owner keeps its grant for as long as it holds
// its request. Optional hold-limit preemption is built only when ARB_HOLD_LIMIT_EN is defined.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic       s1,
    output logic       s0
);

    if (MAX_HOLD < 1 || MAX_HOLD > 15 || (1 << HOLD_W) <= MAX_HOLD) begin : g_param_check
        $error("mux4_rr_arbiter: illegal MAX_HOLD/HOLD_W combination");
    end

    typedef enum logic {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;
    logic       preempt;
    logic       release_now;
    logic [2:0] pick;

    // Returns {found, index} of the first set bit at or after start, wrapping 3->0.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign release_now = (state_q == StGrant) && (!req[sel_q] || preempt);

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    assign preempt = (state_q == StGrant) && req[sel_q] && (hold_q == HoldMax) &&
                     (|(req & ~gnt_q));

    always_comb begin
        hold_d = hold_q;
        if (state_q == StGrant) begin
            if (release_now) begin
                hold_d = '0;
            end else if (hold_q != HoldMax) begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) hold_q <= '0;
        else     hold_q <= hold_d;
    end
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        pick    = 3'b000;
        unique case (state_q)
            StIdle: begin
                pick = rr_pick(req, ptr_q);
                if (pick[2]) begin
                    state_d = StGrant;
                    sel_d   = pick[1:0];
                    gnt_d   = 4'b0001 << pick[1:0];
                    valid_d = 1'b1;
                end
            end
            StGrant: begin
                if (release_now) begin
                    ptr_d = sel_q + 2'd1;
                    // The departing owner is masked so everyone else is served first.
                    pick  = rr_pick(req & ~gnt_q, sel_q + 2'd1);
                    if (pick[2]) begin
                        sel_d = pick[1:0];
                        gnt_d = 4'b0001 << pick[1:0];
                    end else begin
                        state_d = StIdle;
                        gnt_d   = 4'b0000;
                        valid_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = valid_q;
    assign s1        = sel_q[1];
    assign s0        = sel_q[0];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed literal checks plus randomized requests
// compared every cycle against a behavioural round-robin model.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic       s1;
    logic       s0;

    int checks = 0;
    int errors = 0;

    mux4_rr_arbiter #(
        .MAX_HOLD(MAX_HOLD),
        .HOLD_W  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .gnt_valid(gnt_valid),
        .s1       (s1),
        .s0       (s0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner index (-1 = nobody), rotating pointer, last select value.
    int         m_owner = -1;
    int         m_ptr   = 0;
    int         m_sel   = 0;
    int         m_cnt   = 0;
    int         m_win;
    logic [3:0] m_others;
    bit         m_rel;

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_sel   = 0;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            m_win = first_from(req, m_ptr);
            if (m_win >= 0) begin
                m_owner = m_win;
                m_sel   = m_win;
                m_cnt   = 0;
            end
        end else begin
            m_others = req & ~(4'b0001 << m_owner);
            m_rel    = !req[m_owner];
`ifdef ARB_HOLD_LIMIT_EN
            if (!m_rel && m_cnt == MAX_HOLD - 1 && m_others != 4'b0000) m_rel = 1'b1;
`endif
            if (m_rel) begin
                m_ptr   = (m_owner + 1) % 4;
                m_cnt   = 0;
                m_win   = first_from(m_others, m_ptr);
                m_owner = m_win;
                if (m_win >= 0) m_sel = m_win;
            end else if (m_cnt < MAX_HOLD - 1) begin
                m_cnt++;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [3:0] exp_gnt;
        exp_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        check("model_gnt", gnt, exp_gnt);
        check("model_valid", {3'b000, gnt_valid}, {3'b000, m_owner >= 0});
        check("model_sel", {2'b00, s1, s0}, 4'(m_sel));
        check("onehot", {3'b000, $countones(gnt) <= 1}, 4'b0001);
        check("valid_vs_gnt", {3'b000, gnt_valid}, {3'b000, |gnt});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [3:0] g, input logic v,
                              input logic [1:0] sel);
        check({name, "_gnt"}, gnt, g);
        check({name, "_valid"}, {3'b000, gnt_valid}, {3'b000, v});
        check({name, "_sel"}, {2'b00, s1, s0}, {2'b00, sel});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin
        // Reset with all requests asserted, then idle.
        rst = 1'b1;
        req = 4'b1111;
        cyc(2);
        expect_out("reset", 4'b0000, 1'b0, 2'b00);
        rst = 1'b0;
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            expect_out("idle", 4'b0000, 1'b0, 2'b00);
        end

        // Single request: one-cycle latency, select held after release.
        req = 4'b0100;
        cyc(1);
        expect_out("single", 4'b0100, 1'b1, 2'b10);
        cyc(4);
        req = 4'b0000;
        cyc(1);
        expect_out("single_rel", 4'b0000, 1'b0, 2'b10);

        // Rotation 0,1,2,3,0 with no bubble.
        do_reset();
        req = 4'b1111;
        cyc(1);
        for (int k = 0; k < 5; k++) begin
            expect_out("rotate", 4'(1 << (k % 4)), 1'b1, 2'(k % 4));
            if (k < 4) begin
                cyc(1);
                req = 4'b1111 & ~4'(1 << (k % 4));
                cyc(1);
                req = 4'b1111;
            end
        end

`ifndef ARB_HOLD_LIMIT_EN
        // Locked transfer: owner 1 ignores competing requests.
        do_reset();
        req = 4'b0010;
        cyc(1);
        req = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            check("locked", gnt, 4'b0010);
            cyc(1);
        end
        req = 4'b1101;
        cyc(1);
        expect_out("locked_next", 4'b0100, 1'b1, 2'b10);
`endif

        // Mid-grant reset.
        do_reset();
        req = 4'b1000;
        cyc(1);
        expect_out("owner3", 4'b1000, 1'b1, 2'b11);
        rst = 1'b1;
        cyc(1);
        expect_out("midreset", 4'b0000, 1'b0, 2'b00);
        rst = 1'b0;
        req = 4'b1010;
        cyc(1);
        expect_out("after_reset", 4'b0010, 1'b1, 2'b01);

        // Randomized traffic with sticky requests and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 127) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
